// File: rtl/bcd_display_scan_pkg.sv
// Shared types and constants for the multiplexed 3-digit BCD display scanner.
// Holds the controller state encoding and the active-low 7-segment code table.
package bcd_display_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_SHOW    = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [2:0] AN_OFF    = 3'b111;
    localparam logic [2:0] AN_ONES   = 3'b110;
    localparam logic [2:0] AN_TENS   = 3'b101;
    localparam logic [2:0] AN_HUND   = 3'b011;

    // Segment order {g,f,e,d,c,b,a}, active-low, indexed by digit value.
    localparam logic [6:0] SEG_TABLE [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        return (d <= 4'd9) ? SEG_TABLE[d] : SEG_BLANK;
    endfunction

endpackage

// File: rtl/bin2dec.sv
// Combinational 8-bit binary to 3-digit BCD converter (shift-and-add-3).
// Output is {hundreds, tens, ones}, one nibble each.
module bin2dec (
    input  logic [7:0]  bin,
    output logic [11:0] bcd
);

    logic [19:0] sh;

    // NOTE: blocking assignments here on purpose -- each loop pass must see the
    // previous pass's result within the same evaluation.
    always_comb begin
        sh = {12'd0, bin};
        for (int i = 0; i < 8; i++) begin
            for (int d = 0; d < 3; d++) begin
                if (sh[8 + 4*d +: 4] >= 4'd5)
                    sh[8 + 4*d +: 4] = sh[8 + 4*d +: 4] + 4'd3;
            end
            sh = sh << 1;
        end
        bcd = sh[19:8];
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Captures an 8-bit value, converts it to BCD in one cycle, then time-multiplexes
// the three digits onto a shared active-low 7-segment bus with leading-zero blanking.
module bcd_display_scan
    import bcd_display_scan_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] bin,
    output logic       ready,
    output logic [6:0] seg,
    output logic [2:0] an
);

    localparam int unsigned     CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    state_t           state;
    logic [7:0]       value_q;
    logic [11:0]      bcd_q;
    logic [11:0]      bcd_next;
    logic [CNT_W-1:0] scan_cnt;
    logic [1:0]       digit_idx;

    bin2dec u_bin2dec (
        .bin (value_q),
        .bcd (bcd_next)
    );

    assign ready = (state != ST_CONVERT);

    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            value_q   <= '0;
            bcd_q     <= '0;
            scan_cnt  <= '0;
            digit_idx <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        value_q <= bin;
                        state   <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    bcd_q     <= bcd_next;
                    scan_cnt  <= '0;
                    digit_idx <= 2'd0;
                    state     <= ST_SHOW;
                end
                ST_SHOW: begin
                    if (load) begin
                        value_q <= bin;
                        state   <= ST_CONVERT;
                    end else if (scan_cnt == CNT_LAST) begin
                        scan_cnt  <= '0;
                        digit_idx <= (digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1;
                    end else begin
                        scan_cnt <= scan_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic [3:0] digit;
    logic [2:0] an_sel;
    logic       blank;

    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
        digit  = 4'd0;
        an_sel = AN_OFF;
        blank  = 1'b1;
        if (state == ST_SHOW) begin
            case (digit_idx)
                2'd0: begin
                    digit  = bcd_q[3:0];
                    an_sel = AN_ONES;
                    blank  = 1'b0;
                end
                2'd1: begin
                    digit  = bcd_q[7:4];
                    an_sel = AN_TENS;
                    blank  = BLANK_LZ && (bcd_q[11:4] == 8'd0);
                end
                2'd2: begin
                    digit  = bcd_q[11:8];
                    an_sel = AN_HUND;
                    blank  = BLANK_LZ && (bcd_q[11:8] == 4'd0);
                end
                default: blank = 1'b1;
            endcase
        end
        seg = blank ? SEG_BLANK : seg_encode(digit);
        an  = blank ? AN_OFF    : an_sel;
    end

endmodule
